bht_predictor: RTL and testbench

Parametrised branch-history-table predictor for the fetch stage: replaces the single-state predictor with a table of 2^IDX_W two-bit saturating counters indexed by PC, optionally hashed with a global history register. Fetch issues a combinational lookup each cycle. The execute stage returns the resolved outcome, which trains the table and raises a registered mispredict flag that fetch uses to flush. Saturating branch and mispredict counters are kept for performance debug.

---
 rtl/bht_predictor.sv | 118 +++++++++++
 tb/tb_bht_predictor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bht_predictor.sv
// Branch history table: 2^IDX_W two-bit saturating counters indexed by PC.
// Define BHT_GSHARE_EN to XOR the index with a global history register.
module bht_predictor #(
  parameter int          IDX_W    = 6,
  parameter int          GHR_W    = 6,
  parameter logic [1:0]  CNT_INIT = 2'b01,
  parameter int          STAT_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_pc,
  output logic              o_pred_taken,
  output logic [GHR_W-1:0]  o_pred_hist,
  input  logic              i_stall,
  input  logic              i_upd_valid,
  input  logic [31:0]       i_upd_pc,
  input  logic [GHR_W-1:0]  i_upd_hist,
  input  logic              i_upd_taken,
  input  logic              i_upd_pred,
  output logic              o_mispredict,
  output logic [STAT_W-1:0] o_br_cnt,
  output logic [STAT_W-1:0] o_miss_cnt
);

  localparam int N = 1 << IDX_W;

  logic [1:0]       tbl [N];
  logic [IDX_W-1:0] base_lkp;
  logic [IDX_W-1:0] base_upd;
  logic [IDX_W-1:0] idx_lkp;
  logic [IDX_W-1:0] idx_upd;
  logic [1:0]       cur;
  logic [1:0]       nxt;
  logic             fire;
  logic             miss;
  logic             unused;

  assign base_lkp = i_pc[IDX_W+1:2];
  assign base_upd = i_upd_pc[IDX_W+1:2];
  assign fire     = i_upd_valid && !i_stall;
  assign miss     = i_upd_taken != i_upd_pred;

`ifdef BHT_GSHARE_EN
  logic [GHR_W-1:0] ghr;
  logic [GHR_W:0]   ghr_shift;
  logic [IDX_W-1:0] ghr_ext;
  logic [IDX_W-1:0] hist_ext;

  assign ghr_shift = {ghr, i_upd_taken};

  always_comb begin
    ghr_ext                = '0;
    ghr_ext[GHR_W-1:0]     = ghr;
    hist_ext               = '0;
    hist_ext[GHR_W-1:0]    = i_upd_hist;
  end

  assign idx_lkp     = base_lkp ^ ghr_ext;
  assign idx_upd     = base_upd ^ hist_ext;
  assign o_pred_hist = i_rst ? '0 : ghr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ghr <= '0;
    end else if (fire) begin
      ghr <= ghr_shift[GHR_W-1:0];
    end
  end

  assign unused = ^{i_pc[31:IDX_W+2], i_pc[1:0],
                    i_upd_pc[31:IDX_W+2], i_upd_pc[1:0],
                    ghr_shift[GHR_W]};
`else
  assign idx_lkp     = base_lkp;
  assign idx_upd     = base_upd;
  assign o_pred_hist = '0;

  assign unused = ^{i_pc[31:IDX_W+2], i_pc[1:0],
                    i_upd_pc[31:IDX_W+2], i_upd_pc[1:0],
                    i_upd_hist};
`endif

  // No bypass: a same-cycle lookup sees the pre-update counter.
  assign o_pred_taken = i_rst ? CNT_INIT[1] : tbl[idx_lkp][1];
  assign cur          = tbl[idx_upd];

  always_comb begin
    nxt = cur;
    if (i_upd_taken) begin
      if (cur != 2'b11) nxt = cur + 2'b01;
    end else begin
      if (cur != 2'b00) nxt = cur - 2'b01;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N; i++) tbl[i] <= CNT_INIT;
    end else if (fire) begin
      tbl[idx_upd] <= nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_mispredict <= 1'b0;
      o_br_cnt     <= '0;
      o_miss_cnt   <= '0;
    end else begin
      o_mispredict <= fire && miss;
      if (fire) begin
        if (o_br_cnt != '1) o_br_cnt <= o_br_cnt + 1'b1;
        if (miss && o_miss_cnt != '1) o_miss_cnt <= o_miss_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bht_predictor.sv
// Scoreboard bench for bht_predictor; a reference model predicts every
// lookup and every post-edge register value, with a STAT_W=2 twin instance.
module tb_bht_predictor;

  localparam int IDX_W  = 6;
  localparam int GHR_W  = 6;
  localparam int STAT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       pc;
  logic              stall;
  logic              upd_valid;
  logic [31:0]       upd_pc;
  logic [GHR_W-1:0]  upd_hist;
  logic              upd_taken;
  logic              upd_pred;
  logic              pred_taken;
  logic [GHR_W-1:0]  pred_hist;
  logic              mispredict;
  logic [STAT_W-1:0] br_cnt;
  logic [STAT_W-1:0] miss_cnt;
  logic              s_pred_taken;
  logic [GHR_W-1:0]  s_pred_hist;
  logic              s_mispredict;
  logic [1:0]        s_br_cnt;
  logic [1:0]        s_miss_cnt;

  always #5 clk = ~clk;

  bht_predictor #(.IDX_W(IDX_W), .GHR_W(GHR_W), .STAT_W(STAT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_pc(pc),
    .o_pred_taken(pred_taken), .o_pred_hist(pred_hist),
    .i_stall(stall), .i_upd_valid(upd_valid), .i_upd_pc(upd_pc),
    .i_upd_hist(upd_hist), .i_upd_taken(upd_taken),
    .i_upd_pred(upd_pred), .o_mispredict(mispredict),
    .o_br_cnt(br_cnt), .o_miss_cnt(miss_cnt)
  );

  bht_predictor #(.IDX_W(IDX_W), .GHR_W(GHR_W), .STAT_W(2)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_pc(pc),
    .o_pred_taken(s_pred_taken), .o_pred_hist(s_pred_hist),
    .i_stall(stall), .i_upd_valid(upd_valid), .i_upd_pc(upd_pc),
    .i_upd_hist(upd_hist), .i_upd_taken(upd_taken),
    .i_upd_pred(upd_pred), .o_mispredict(s_mispredict),
    .o_br_cnt(s_br_cnt), .o_miss_cnt(s_miss_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  task automatic push(string tag, logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_chk(logic [31:0] act);
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check(e.tag, act, e.exp);
    end
  endtask

  logic [1:0]       mtab [1 << IDX_W];
  logic [GHR_W-1:0] mghr;
  int               mbr;
  int               mmiss;

  function automatic logic [IDX_W-1:0] midx(logic [31:0] a,
                                            logic [GHR_W-1:0] h);
    logic [IDX_W-1:0] x;
    x = '0;
`ifdef BHT_GSHARE_EN
    x[GHR_W-1:0] = h;
`endif
    return a[IDX_W+1:2] ^ x;
  endfunction

  function automatic int sat(int v, int m);
    return (v > m) ? m : v;
  endfunction

  task automatic cyc(logic r, logic [31:0] lpc, logic v, logic st,
                     logic [31:0] upc, logic tk, logic pr);
    logic [IDX_W-1:0] ui;
    logic [1:0]       c;
    logic             fire;
    logic [GHR_W-1:0] hexp;
    @(negedge clk);
    rst       = r;
    pc        = lpc;
    upd_valid = v;
    stall     = st;
    upd_pc    = upc;
    upd_hist  = mghr;
    upd_taken = tk;
    upd_pred  = pr;
    hexp = '0;
`ifdef BHT_GSHARE_EN
    hexp = mghr;
`endif
    push("pred_taken", r ? 32'd0 : 32'(mtab[midx(lpc, mghr)][1]));
    push("pred_hist", r ? 32'd0 : 32'(hexp));
    #1;
    pop_chk(32'(pred_taken));
    pop_chk(32'(pred_hist));
    fire = v && !st && !r;
    if (r) begin
      for (int i = 0; i < (1 << IDX_W); i++) mtab[i] = 2'b01;
      mghr  = '0;
      mbr   = 0;
      mmiss = 0;
    end else if (fire) begin
      ui = midx(upc, mghr);
      c  = mtab[ui];
      if (tk && c < 2'd3) c = c + 2'd1;
      if (!tk && c > 2'd0) c = c - 2'd1;
      mtab[ui] = c;
      mghr = {mghr[GHR_W-2:0], tk};
      mbr++;
      if (tk != pr) mmiss++;
    end
    push("mispredict", 32'(fire && (tk != pr)));
    push("br_cnt", 32'(sat(mbr, 65535)));
    push("miss_cnt", 32'(sat(mmiss, 65535)));
    push("sat_br_cnt", 32'(sat(mbr, 3)));
    push("sat_miss_cnt", 32'(sat(mmiss, 3)));
    @(posedge clk);
    #1;
    pop_chk(32'(mispredict));
    pop_chk(32'(br_cnt));
    pop_chk(32'(miss_cnt));
    pop_chk(32'(s_br_cnt));
    pop_chk(32'(s_miss_cnt));
  endtask

  initial begin
    rst = 1'b1; pc = '0; stall = 1'b0; upd_valid = 1'b0;
    upd_pc = '0; upd_hist = '0; upd_taken = 1'b0; upd_pred = 1'b0;
    mghr = '0; mbr = 0; mmiss = 0;
    for (int i = 0; i < (1 << IDX_W); i++) mtab[i] = 2'b01;

    cyc(1, 32'h40, 0, 0, 0, 0, 0);
    cyc(1, 32'h40, 1, 0, 32'h40, 1, 0);
    cyc(0, 32'h40, 0, 0, 0, 0, 0);
    check("reset_pred_0x40", 32'(pred_taken), 32'd0);
    check("reset_br_cnt", 32'(br_cnt), 32'd0);

    for (int k = 0; k < 4; k++) cyc(0, 32'h40, 1, 0, 32'h40, 1, 0);
`ifndef BHT_GSHARE_EN
    check("trained_pred_0x40", 32'(pred_taken), 32'd1);
`endif
    check("train_miss_cnt", 32'(miss_cnt), 32'd4);
    check("train_br_cnt", 32'(br_cnt), 32'd4);
    cyc(0, 32'h140, 0, 0, 0, 0, 0);
`ifndef BHT_GSHARE_EN
    check("alias_pred_0x140", 32'(pred_taken), 32'd1);
`endif

    for (int k = 0; k < 3; k++) cyc(0, 32'hC0, 1, 1, 32'hC0, 1, 0);
    check("stall_br_cnt", 32'(br_cnt), 32'd4);
    cyc(0, 32'hC0, 1, 0, 32'hC0, 1, 0);
    cyc(0, 32'hC0, 0, 0, 0, 0, 0);
    check("unstall_br_cnt", 32'(br_cnt), 32'd5);

    cyc(0, 32'h80, 1, 0, 32'h80, 1, 0);
`ifndef BHT_GSHARE_EN
    check("same_cycle_next", 32'(pred_taken), 32'd1);
`endif
    cyc(1, 32'h80, 1, 0, 32'h80, 1, 0);
    cyc(0, 32'h80, 0, 0, 0, 0, 0);
    check("rst_drop_pred", 32'(pred_taken), 32'd0);
    check("rst_drop_br_cnt", 32'(br_cnt), 32'd0);

    cyc(0, 32'h100, 1, 0, 32'h100, 1, 1);
    cyc(0, 32'h100, 1, 0, 32'h100, 0, 1);
    cyc(0, 32'h100, 1, 0, 32'h100, 1, 0);
    cyc(0, 32'h100, 1, 0, 32'h100, 1, 1);
    cyc(0, 32'h100, 1, 0, 32'h100, 1, 1);
`ifdef BHT_GSHARE_EN
    check("ghr_low5", 32'(pred_hist[4:0]), 32'h17);
`endif
    check("sat_br_saturated", 32'(s_br_cnt), 32'd3);

    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 60) == 0),
          {24'd0, 8'($urandom_range(0, 255))} & 32'hFC | 32'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
          {22'd0, 10'($urandom_range(0, 1023))},
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
